// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, operands shifted LSB first,
// carry held in a flop between bits, start/done handshake to a controller.

// One-bit full adder cell reused by the serial datapath.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    ra_q, ra_d;
    logic [N-1:0]    rb_q, rb_d;
    logic [N-1:0]    s_q, s_d;
    logic            cy_q, cy_d;
    logic            cout_q, cout_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            fa_sum;
    logic            fa_carry;
    logic            last_bit;

    // The single adder cell always looks at the current LSBs and the carry flop.
    fulladder u_fa (
        .A    (ra_q[0]),
        .B    (rb_q[0]),
        .Cin  (cy_q),
        .S    (fa_sum),
        .Cout (fa_carry)
    );

    assign last_bit = (cnt_q == CW'(N - 1));

    // State register; reset wins over every other input, including a same-edge start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE always returns to IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode straight from the state flops; no input reaches an output.
    always_comb begin
        busy = (state_q == ADD) || (state_q == DONE);
        done = (state_q == DONE);
    end

    // Datapath next values: load on acceptance, shift one bit per ADD cycle.
    always_comb begin
        ra_d   = ra_q;
        rb_d   = rb_q;
        s_d    = s_q;
        cy_d   = cy_q;
        cout_d = cout_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d   = A;
                    rb_d   = B;
                    cy_d   = Cin;
                    s_d    = '0;
                    cout_d = 1'b0;
                    cnt_d  = '0;
                end
            end
            ADD: begin
                s_d   = {fa_sum, s_q[N-1:1]};
                ra_d  = {1'b0, ra_q[N-1:1]};
                rb_d  = {1'b0, rb_q[N-1:1]};
                cy_d  = fa_carry;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    cout_d = fa_carry;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q   <= '0;
            rb_q   <= '0;
            s_q    <= '0;
            cy_q   <= 1'b0;
            cout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            s_q    <= s_d;
            cy_q   <= cy_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;

endmodule
